key_debounce_conditioner: RTL

//  Conditions one raw active-low DE2 pushbutton (e.g. KEY[1]) before it reaches the SoC PIO input.
//  - Two-flop synchroniser, then a debounce FSM.
//  - Outputs: one-cycle press/release pulses and a sticky press-pending flag with an ack handshake.
//  - Also keeps a wrapping press counter.
//  - Sits between the board pin and the key_1 PIO export, so software sees one clean event per press.

---
 rtl/key_debounce_conditioner.sv | 135 +++++++++++++
 1 files changed

// File: rtl/key_debounce_conditioner.sv
// Conditions one raw active-low pushbutton: two-flop synchroniser, debounce FSM,
// registered level/press/release outputs, sticky press-pending flag and wrapping press counter.
module key_debounce_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned COUNT_W         = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               key_n_i,
    input  logic               ack_i,
    output logic               key_level_o,
    output logic               press_pulse_o,
    output logic               release_pulse_o,
    output logic               press_pending_o,
    output logic [COUNT_W-1:0] press_count_o
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ST_RELEASED     = 2'd0;
    localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] ST_PRESSED      = 2'd2;
    localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

    generate
        if (DEBOUNCE_CYCLES < 2) begin : g_bad_param
            $error("key_debounce_conditioner: DEBOUNCE_CYCLES must be >= 2");
        end
    endgenerate

    logic               s1_q;
    logic               sync_q;
    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               level_q, level_d;
    logic               press_pulse_q, press_pulse_d;
    logic               release_pulse_q, release_pulse_d;
    logic               pending_q, pending_d;
    logic [COUNT_W-1:0] count_q, count_d;

    // Debounce FSM: a WAIT state must see DEBOUNCE_CYCLES stable samples before accepting.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        press_pulse_d   = 1'b0;
        release_pulse_d = 1'b0;
        case (state_q)
            ST_RELEASED: begin
                if (sync_q) begin
                    state_d = ST_PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!sync_q) begin
                    state_d = ST_RELEASED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d       = ST_PRESSED;
                    press_pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_PRESSED: begin
                if (!sync_q) begin
                    state_d = ST_RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_RELEASE_WAIT: begin
                if (sync_q) begin
                    state_d = ST_PRESSED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d         = ST_RELEASED;
                    release_pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

    // Level is registered from the next state so it rises/falls with the matching pulse.
    always_comb begin
        level_d = (state_d == ST_PRESSED) || (state_d == ST_RELEASE_WAIT);
    end

    // Pending/count follow the visible pulse; a coinciding ack loses to the new press.
    always_comb begin
        pending_d = pending_q;
        count_d   = count_q;
        if (press_pulse_q) begin
            pending_d = 1'b1;
            count_d   = count_q + COUNT_W'(1);
        end else if (ack_i) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q            <= 1'b0;
            sync_q          <= 1'b0;
            state_q         <= ST_RELEASED;
            cnt_q           <= '0;
            level_q         <= 1'b0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
            pending_q       <= 1'b0;
            count_q         <= '0;
        end else begin
            s1_q            <= ~key_n_i;
            sync_q          <= s1_q;
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            level_q         <= level_d;
            press_pulse_q   <= press_pulse_d;
            release_pulse_q <= release_pulse_d;
            pending_q       <= pending_d;
            count_q         <= count_d;
        end
    end

    assign key_level_o     = level_q;
    assign press_pulse_o   = press_pulse_q;
    assign release_pulse_o = release_pulse_q;
    assign press_pending_o = pending_q;
    assign press_count_o   = count_q;

endmodule
